// File: rtl/headdrop_scheduler.sv
// Head-drop controller for the four-port shared buffer.
// Picks an over-threshold, non-empty port in round-robin order, asks the
// queue manager to drop that port's head packet, and reports the drop
// back to the statistics block. New work starts only while the dequeue
// path is idle.
module headdrop_scheduler #(
    parameter int ACK_TIMEOUT = 16,
    parameter int HOLDOFF     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  bitmap_dt,
    input  logic [3:0]  port_nonempty,
    input  logic        deq_busy,
    output logic        hd_req,
    output logic [3:0]  hd_port,
    input  logic        hd_ack,
    input  logic [10:0] hd_len,
    output logic        headdrop_out,
    output logic [3:0]  headdrop_out_port,
    output logic [10:0] headdrop_pkt_len_out,
    output logic [15:0] drop_count,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        REPORT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [3:0]  cand;
    logic [1:0]  grant_port;
    logic [1:0]  rr_ptr;
    logic [1:0]  req_port;
    logic [1:0]  rep_port;
    logic [10:0] rep_len;
    logic [7:0]  wait_cnt;
    logic [3:0]  hold_cnt;
    logic [15:0] drop_cnt;
    logic        timeout_flag;

    logic        start_grant;
    logic        ack_len_nz;
    logic        wait_expired;
    logic        hold_done;

    // First candidate at or after ptr, wrapping modulo 4; lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (c[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    assign cand         = ~bitmap_dt & port_nonempty;
    assign grant_port   = rr_pick(cand, rr_ptr);
    assign start_grant  = (state == IDLE) && enable && !deq_busy && (cand != 4'b0000);
    assign ack_len_nz   = (hd_len != 11'd0);
    assign wait_expired = (wait_cnt == 8'(ACK_TIMEOUT - 1));
    assign hold_done    = (hold_cnt == 4'(HOLDOFF - 1));

    // Next-state decode; ack beats a timeout landing in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_grant) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (hd_ack) begin
                    state_nx = ack_len_nz ? REPORT : HOLD;
                end else if (wait_expired) begin
                    state_nx = HOLD;
                end
            end
            REPORT: begin
                state_nx = HOLD;
            end
            HOLD: begin
                if (hold_done) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant bookkeeping: round-robin pointer and the port held during REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 2'd0;
            req_port <= 2'd0;
        end else if (start_grant) begin
            rr_ptr   <= grant_port + 2'd1;
            req_port <= grant_port;
        end
    end

    // Ack wait counter: cleared on grant, advances every REQ cycle without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (start_grant) begin
            wait_cnt <= 8'd0;
        end else if ((state == REQ) && !hd_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Holdoff counter: runs only in HOLD so each visit starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 4'd0;
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 4'd1;
        end else begin
            hold_cnt <= 4'd0;
        end
    end

    // Capture port and length of a real drop for the report pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_port <= 2'd0;
            rep_len  <= 11'd0;
        end else if ((state == REQ) && hd_ack && ack_len_nz) begin
            rep_port <= req_port;
            rep_len  <= hd_len;
        end
    end

    // Drop counter advances once per REPORT visit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (state == REPORT) begin
            drop_cnt <= sat_inc16(drop_cnt);
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_flag <= 1'b0;
        end else if ((state == REQ) && !hd_ack && wait_expired) begin
            timeout_flag <= 1'b1;
        end
    end

    // Outputs decode straight from registers; no input reaches an output.
    assign hd_req               = (state == REQ);
    assign hd_port              = {2'b00, req_port};
    assign headdrop_out         = (state == REPORT);
    assign headdrop_out_port    = {2'b00, rep_port};
    assign headdrop_pkt_len_out = rep_len;
    assign drop_count           = drop_cnt;
    assign timeout_err          = timeout_flag;
    assign busy                 = (state != IDLE);

endmodule

// File: doc/headdrop_scheduler.md
# headdrop_scheduler

Head-drop controller for the four-port shared buffer. It watches the per-port threshold bitmap from the statistics block and picks an over-threshold, non-empty port in round-robin order. It then runs a request/acknowledge transaction with the queue manager to drop that port's head packet, and reports the drop back to the statistics block on the headdrop_out interface. It sits between the statistics block and the queue manager, and uses read bandwidth only when the dequeue path is idle.

## Interface
- ACK_TIMEOUT, 16: maximum number of cycles hd_req stays high without hd_ack (range 2..255).
- HOLDOFF, 2: cycles spent in HOLD after every transaction (range 1..15).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; allows new transactions to start.
- bitmap_dt  in  4  from statistics; bit i = 1 means port i is below threshold with 256 B margin.
- port_nonempty  in  4  from queue manager; bit i = 1 means port i queue holds at least one packet.
- deq_busy  in  1  dequeue path active this cycle; blocks new grants.
- hd_req  out  1  head-drop request to queue manager.
- hd_port  out  4  port index for hd_req; values 0..3.
- hd_ack  in  1  queue manager completed the request this cycle.
- hd_len  in  11  length of the dropped packet, valid with hd_ack; 0 means nothing was dropped.
- headdrop_out  out  1  one-cycle pulse to statistics.
- headdrop_out_port  out  4  port of the reported drop.
- headdrop_pkt_len_out  out  11  bytes dropped.
- drop_count  out  16  packets dropped since reset; saturates at 0xFFFF.
- timeout_err  out  1  sticky; set on ack timeout, cleared only by rst.
- busy  out  1  high in every state except IDLE.

## Operation
- Candidate vector: cand[i] = ~bitmap_dt[i] & port_nonempty[i]. It is sampled only in IDLE.
- Round-robin pointer rr_ptr (2 bit, reset 0). The search order is rr_ptr, rr_ptr+1, ... (mod 4). On a grant to port p, rr_ptr becomes p+1 mod 4.
- States:
  - IDLE → REQ when enable & ~deq_busy & (cand != 0). The grant port is latched into hd_port, and wait_cnt is cleared.
  - REQ: hd_req = 1, hd_port is held stable.
    - On hd_ack with hd_len != 0: latch the length and go to REPORT.
    - On hd_ack with hd_len == 0: go to HOLD. No report, no count.
    - Without ack: wait_cnt increments. If wait_cnt == ACK_TIMEOUT-1, set timeout_err and go to HOLD.
    - If ack and timeout fall in the same cycle, ack wins.
  - REPORT: headdrop_out = 1 for exactly one cycle, with the latched port and length. drop_count increments, saturating. Next state is HOLD.
  - HOLD: counts HOLDOFF cycles, then returns to IDLE. This lets the statistics bitmap settle before the next decision.
- Deasserting enable, or asserting deq_busy, outside IDLE does not abort anything. The current transaction completes. Both signals are checked only in IDLE.
- hd_ack is ignored outside REQ.
- Port index widths are 4 bits. The upper 2 bits of hd_port and headdrop_out_port are always 0.

## Timing
- Reset values: hd_req=0, hd_port=0, headdrop_out=0, headdrop_out_port=0, headdrop_pkt_len_out=0, drop_count=0, timeout_err=0, busy=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-transaction forces all of the above immediately. No pulse is emitted afterwards.
- Candidate visible in IDLE at cycle t → hd_req=1 and busy=1 from cycle t+1.
- hd_ack sampled at cycle a → hd_req=0 at a+1 and headdrop_out=1 at a+1 only. This is 1 cycle of latency ack→report.
- HOLD occupies cycles a+2 .. a+1+HOLDOFF. The earliest next hd_req is at cycle a+3+HOLDOFF.
- Timeout: hd_req is high for exactly ACK_TIMEOUT cycles. timeout_err rises the cycle after the last of them.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single drop: bitmap_dt=4'b1011, port_nonempty=4'b1111, ack with hd_len=300 on the 3rd hd_req cycle. Required: hd_port=2; one headdrop_out pulse carrying port 2 and length 300; drop_count=1; next hd_req no earlier than HOLDOFF+2 cycles after the pulse.
- Round-robin: all four ports over threshold and nonempty, immediate acks, 8 transactions. Required: hd_port sequence 0,1,2,3,0,1,2,3.
- Blocking: candidate present with deq_busy=1 for 10 cycles, then 0. Required: hd_req stays 0 throughout the blocked cycles and rises the cycle after deq_busy is seen low.
- Empty and timeout:
  - Ack with hd_len=0. Required: no headdrop_out, drop_count unchanged.
  - Later, no ack with ACK_TIMEOUT=16. Required: hd_req high for exactly 16 cycles, timeout_err=1 and stays set.
- Mid-operation events:
  - Deassert enable while in REQ, then ack. Required: the report still occurs.
  - Assert rst while in REPORT. Required: all outputs return to 0 asynchronously.
  - Hold drop_count at 0xFFFF and perform one more drop. Required: drop_count stays at 0xFFFF.
